instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 187 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: turns a class/field request into a 32-bit instruction word
// and queues it, with its illegal flag, in a 2-entry FIFO. Illegal requests become NOPs.
module instr_encoder (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_class,
    input  logic [2:0]  in_funct3,
    input  logic        in_alt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [19:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_illegal,
    output logic [15:0] enc_count,
    output logic [7:0]  err_count
);

    localparam logic [3:0] CLASS_R_TYPE = 4'd0;
    localparam logic [3:0] CLASS_ARITH_I = 4'd1;
    localparam logic [3:0] CLASS_LOAD = 4'd2;
    localparam logic [3:0] CLASS_STORE = 4'd3;
    localparam logic [3:0] CLASS_SUBI = 4'd4;
    localparam logic [3:0] CLASS_JAL = 4'd5;
    localparam logic [3:0] CLASS_JALR = 4'd6;
    localparam logic [3:0] CLASS_BRANCH = 4'd7;
    localparam logic [3:0] CLASS_AUIPC = 4'd8;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_ARITH_I = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_SUBI = 7'b0011111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [31:0] enc_instr;
    logic        enc_illegal;
    logic [31:0] raw_instr;
    logic [32:0] new_entry;

    logic [1:0]  state_q, state_d;
    logic [32:0] head_q, head_d;
    logic [32:0] tail_q, tail_d;
    logic [15:0] enc_count_q, enc_count_d;
    logic [7:0]  err_count_q, err_count_d;

    logic push;
    logic pop;

    // Field placement per class; the shift-immediate form keeps funct7 in the top bits.
    always_comb begin
        raw_instr = NOP_INSTR;
        enc_illegal = 1'b0;
        case (in_class)
            CLASS_R_TYPE: begin
                raw_instr = {1'b0, in_alt, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_R_TYPE};
                enc_illegal = in_alt && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
            end
            CLASS_ARITH_I: begin
                if ((in_funct3 == 3'b001) || (in_funct3 == 3'b101)) begin
                    raw_instr = {1'b0, in_alt, 4'b0000, in_imm[5:0], in_rs1, in_funct3, in_rd, OP_ARITH_I};
                    enc_illegal = in_alt && (in_funct3 == 3'b001);
                end else begin
                    raw_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ARITH_I};
                end
            end
            CLASS_LOAD: begin
                raw_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            end
            CLASS_STORE: begin
                raw_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            end
            CLASS_SUBI: begin
                raw_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_SUBI};
            end
            CLASS_JAL: begin
                raw_instr = {in_imm[19], in_imm[9:0], in_imm[10], in_imm[18:11], in_rd, OP_JAL};
            end
            CLASS_JALR: begin
                raw_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            end
            CLASS_BRANCH: begin
                raw_instr = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                             in_imm[3:0], in_imm[10], OP_BRANCH};
                enc_illegal = (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
            end
            CLASS_AUIPC: begin
                raw_instr = {in_imm[19:0], in_rd, OP_AUIPC};
            end
            default: begin
                raw_instr = NOP_INSTR;
                enc_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        enc_instr = enc_illegal ? NOP_INSTR : raw_instr;
        new_entry = {enc_illegal, enc_instr};
    end

    assign in_ready = (state_q != ST_FULL);
    assign out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    // head always holds the oldest entry, so a pop from FULL shifts tail forward.
    always_comb begin
        state_d = state_q;
        head_d = head_q;
        tail_d = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d = new_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = new_entry;
                end else if (push) begin
                    tail_d = new_entry;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_comb begin
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (push) begin
            enc_count_d = enc_count_q + 16'd1;
            if (enc_illegal && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            head_q <= '0;
            tail_q <= '0;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q <= head_d;
            tail_q <= tail_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    // Outputs are gated so a drained FIFO never shows a stale word or flag.
    assign out_instr = out_valid ? head_q[31:0] : 32'h0000_0000;
    assign out_illegal = out_valid && head_q[32];
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: hand-computed encodings, FIFO
// ordering/backpressure, counter behaviour and reset during activity.
module tb_instr_encoder;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_class;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [19:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_illegal;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    int checkCount = 0;
    int errorCount = 0;

    instr_encoder dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_class(in_class),
        .in_funct3(in_funct3),
        .in_alt(in_alt),
        .in_rd(in_rd),
        .in_rs1(in_rs1),
        .in_rs2(in_rs2),
        .in_imm(in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_illegal(out_illegal),
        .enc_count(enc_count),
        .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [19:0] imm);
        in_class = cls;
        in_funct3 = f3;
        in_alt = alt;
        in_rd = rd;
        in_rs1 = rs1;
        in_rs2 = rs2;
        in_imm = imm;
        in_valid = 1'b1;
    endtask

    // One request from EMPTY with out_ready=1: visible one cycle later, drained the next.
    task automatic encodeOne(input string tag, input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [19:0] imm, input logic [31:0] expInstr, input logic expIllegal);
        out_ready = 1'b1;
        applyStimulus(cls, f3, alt, rd, rs1, rs2, imm);
        tick();
        in_valid = 1'b0;
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, "_instr"}, out_instr, expInstr);
        checkOutput({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, expIllegal});
        tick();
        checkOutput({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_class = '0;
        in_funct3 = '0;
        in_alt = 1'b0;
        in_rd = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_imm = '0;
        tick();
        tick();
        reset = 1'b0;

        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_enc_count", {16'd0, enc_count}, 32'd0);
        checkOutput("rst_err_count", {24'd0, err_count}, 32'd0);

        encodeOne("r_add", 4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 20'h0, 32'h002081B3, 1'b0);
        encodeOne("r_sub", 4'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 20'h0, 32'h402081B3, 1'b0);
        encodeOne("store", 4'd3, 3'b011, 1'b0, 5'd0, 5'd1, 5'd2, 20'h00008, 32'h0020B423, 1'b0);
        encodeOne("branch", 4'd7, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 20'h00004, 32'h00208463, 1'b0);
        encodeOne("auipc", 4'd8, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 20'h12345, 32'h12345297, 1'b0);
        encodeOne("jal", 4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 20'h80001, 32'h802000EF, 1'b0);
        encodeOne("srai", 4'd1, 3'b101, 1'b1, 5'd4, 5'd2, 5'd0, 20'h00003, 32'h40315213, 1'b0);
        encodeOne("subi", 4'd4, 3'b111, 1'b0, 5'd1, 5'd1, 5'd0, 20'h00FFF, 32'hFFF0809F, 1'b0);
        checkOutput("legal_enc_count", {16'd0, enc_count}, 32'd8);
        checkOutput("legal_err_count", {24'd0, err_count}, 32'd0);

        doReset();
        encodeOne("ill_class15", 4'd15, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 20'h0, 32'h00000013, 1'b1);
        checkOutput("ill_err1", {24'd0, err_count}, 32'd1);
        checkOutput("ill_enc1", {16'd0, enc_count}, 32'd1);
        encodeOne("ill_branch010", 4'd7, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 20'h4, 32'h00000013, 1'b1);
        checkOutput("ill_err2", {24'd0, err_count}, 32'd2);
        encodeOne("ill_slli_alt", 4'd1, 3'b001, 1'b1, 5'd4, 5'd2, 5'd0, 20'h3, 32'h00000013, 1'b1);
        encodeOne("ill_r_alt001", 4'd0, 3'b001, 1'b1, 5'd3, 5'd1, 5'd2, 20'h0, 32'h00000013, 1'b1);
        checkOutput("ill_err4", {24'd0, err_count}, 32'd4);
        checkOutput("ill_enc4", {16'd0, enc_count}, 32'd4);

        // Backpressure: A and B fill the FIFO, C waits, then all drain in order.
        doReset();
        out_ready = 1'b0;
        applyStimulus(4'd8, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 20'h00001);
        tick();
        applyStimulus(4'd8, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 20'h00002);
        tick();
        checkOutput("bp_full_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(4'd8, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 20'h00003);
        tick();
        checkOutput("bp_held_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_held_A", out_instr, 32'h00001017);
        checkOutput("bp_enc2", {16'd0, enc_count}, 32'd2);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_drain_B", out_instr, 32'h00002017);
        checkOutput("bp_ready_again", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_drain_C", out_instr, 32'h00003017);
        checkOutput("bp_C_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_enc3", {16'd0, enc_count}, 32'd3);
        tick();
        checkOutput("bp_empty", {31'd0, out_valid}, 32'd0);

        // Streaming in ONE: each cycle pushes one and pops one.
        applyStimulus(4'd8, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 20'h00100);
        tick();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(4'd8, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 20'h00100 + 20'(i));
            tick();
            checkOutput($sformatf("stream_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("stream_ready_%0d", i), {31'd0, in_ready}, 32'd1);
            checkOutput($sformatf("stream_instr_%0d", i), out_instr, 32'h00100017 + (32'(i) << 12));
        end
        in_valid = 1'b0;
        checkOutput("stream_enc", {16'd0, enc_count}, 32'd14);
        tick();

        // Error counter saturation.
        doReset();
        out_ready = 1'b1;
        applyStimulus(4'd15, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 20'h0);
        for (int i = 0; i < 260; i++) begin
            tick();
            if (i == 253) checkOutput("sat_err_254", {24'd0, err_count}, 32'd254);
        end
        in_valid = 1'b0;
        checkOutput("sat_err_ff", {24'd0, err_count}, 32'h000000FF);
        checkOutput("sat_enc_260", {16'd0, enc_count}, 32'd260);
        tick();

        // Reset while FULL with a push pending.
        out_ready = 1'b0;
        applyStimulus(4'd8, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 20'h00001);
        tick();
        tick();
        checkOutput("rf_full", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        checkOutput("rf_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rf_enc", {16'd0, enc_count}, 32'd0);
        checkOutput("rf_err", {24'd0, err_count}, 32'd0);
        checkOutput("rf_in_ready", {31'd0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
